rst_sequencer: RTL and testbench

- Parametrised power-on and reset sequencer for the camera-to-HDMI pipeline. Runs on clk_100Mhz.
- Replaces the single fixed 20 ms power-on timer with:
  - a filtered PLL-lock qualifier;
  - staged release of N independent active-low reset domains (camera, capture/mixer, AXI writer/reader, video/HDMI);
  - a wait for camera configuration done, with timeout and bounded retry;
  - lock-loss recovery and a soft-reset request.

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/rst_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_rst_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared constants and state encoding for the reset sequencer
package rst_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;

    // Defaults at 100 MHz: 20 ms power-on hold, 10 us stage gap, 0.5 s config timeout.
    localparam int DEF_POR_CYCLES       = 2000000;
    localparam int DEF_STAGE_GAP_CYCLES = 1000;
    localparam int DEF_DONE_TIMEOUT     = 50000000;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_POR_WAIT  = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_WAIT_CFG  = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } rst_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser, async active-low reset to 0
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bits
//   q     : synchronised output bits
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged power-on/reset sequencer with lock qualify, config wait and retry
//   clk_100Mhz   : system clock
//   sys_rst_n    : asynchronous active-low reset
//   locked       : clock-wizard lock (asynchronous)
//   cfg_done     : camera configuration done level (from clk_25Mhz domain)
//   soft_rst     : one-cycle request to restart the sequence
//   domain_rst_n : per-domain active-low resets, released in index order
//   all_ready    : high in RUN
//   fault        : high in FAULT
//   state        : current state encoding
//   retry_cnt    : config timeouts taken in this sequence
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS      = 4,
    parameter int POR_CYCLES       = DEF_POR_CYCLES,
    parameter int STAGE_GAP_CYCLES = DEF_STAGE_GAP_CYCLES,
    parameter int LOCK_FILTER      = 16,
    parameter int DONE_TIMEOUT     = DEF_DONE_TIMEOUT,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 32
) (
    input  logic                   clk_100Mhz,
    input  logic                   sys_rst_n,
    input  logic                   locked,
    input  logic                   cfg_done,
    input  logic                   soft_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   all_ready,
    output logic                   fault,
    output logic [STATE_W-1:0]     state,
    output logic [RETRY_W-1:0]     retry_cnt
);

    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int FILT_W = $clog2(LOCK_FILTER + 1);

    localparam logic [CNT_W-1:0]   POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [FILT_W-1:0]  FILT_FULL = FILT_W'(LOCK_FILTER);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic locked_s;
    logic cfg_done_s;

    sync_2ff #(
        .WIDTH (2)
    ) u_sync (
        .clk   (clk_100Mhz),
        .rst_n (sys_rst_n),
        .d     ({cfg_done, locked}),
        .q     ({cfg_done_s, locked_s})
    );

    // Lock filter: counts consecutive synced-high cycles, saturates at LOCK_FILTER.
    logic [FILT_W-1:0] filt_q;
    logic              lock_ok;

    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            filt_q <= '0;
        end else if (!locked_s) begin
            filt_q <= '0;
        end else if (filt_q != FILT_FULL) begin
            filt_q <= filt_q + FILT_W'(1);
        end
    end

    assign lock_ok = (filt_q == FILT_FULL);

    rst_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   all_ready_q, all_ready_d;
    logic                   fault_q, fault_d;
    logic                   lock_watched;

    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_q       <= '0;
            retry_q     <= '0;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_q       <= dom_d;
            retry_q     <= retry_d;
            all_ready_q <= all_ready_d;
            fault_q     <= fault_d;
        end
    end

    // FAULT deliberately ignores lock loss so the fault stays visible.
    assign lock_watched = (state_q == ST_POR_WAIT) || (state_q == ST_RELEASE) ||
                          (state_q == ST_WAIT_CFG) || (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        retry_d = retry_q;

        if (soft_rst) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            retry_d = '0;
        end else if (lock_watched && !lock_ok) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    cnt_d = '0;
                    idx_d = '0;
                    dom_d = '0;
                    if (lock_ok) begin
                        state_d = ST_POR_WAIT;
                    end
                end
                ST_POR_WAIT: begin
                    if (cnt_q == POR_LAST) begin
                        cnt_d    = '0;
                        idx_d    = '0;
                        dom_d    = '0;
                        // Domain 0 is released on the same edge that enters RELEASE.
                        dom_d[0] = 1'b1;
                        state_d  = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (idx_q == IDX_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_CFG;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_d        = '0;
                        idx_d        = idx_q + IDX_W'(1);
                        dom_d[idx_d] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_CFG: begin
                    if (cfg_done_s) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d = '0;
                        idx_d = '0;
                        dom_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ST_POR_WAIT;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
                ST_FAULT: begin
                    dom_d = '0;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                end
            endcase
        end

        all_ready_d = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    assign domain_rst_n = dom_q;
    assign all_ready    = all_ready_q;
    assign fault        = fault_q;
    assign state        = state_q;
    assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed self-checking bench for rst_sequencer
module tb_rst_sequencer;
    import rst_seq_pkg::*;

    logic       clk_100Mhz = 1'b0;
    logic       sys_rst_n;
    logic       locked;
    logic       cfg_done;
    logic       soft_rst;
    logic [3:0] domain_rst_n;
    logic       all_ready;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    rst_sequencer #(
        .NUM_DOMAINS      (4),
        .POR_CYCLES       (100),
        .STAGE_GAP_CYCLES (10),
        .LOCK_FILTER      (4),
        .DONE_TIMEOUT     (200),
        .MAX_RETRY        (2),
        .CNT_W            (32)
    ) dut (
        .clk_100Mhz   (clk_100Mhz),
        .sys_rst_n    (sys_rst_n),
        .locked       (locked),
        .cfg_done     (cfg_done),
        .soft_rst     (soft_rst),
        .domain_rst_n (domain_rst_n),
        .all_ready    (all_ready),
        .fault        (fault),
        .state        (state),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    task automatic wait_dom(input string tag, input logic [3:0] v, input int budget);
        int n;
        n = 0;
        while (domain_rst_n !== v && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(domain_rst_n), 32'(v));
    endtask

    task automatic measure(input logic [2:0] st, output int n);
        n = 0;
        while (state === st && n < 5000) begin
            n++;
            tick();
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] st, input logic [3:0] dom,
                                 input logic rdy, input logic flt, input logic [1:0] rc);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_dom"}, 32'(domain_rst_n), 32'(dom));
        check({tag, "_ready"}, 32'(all_ready), 32'(rdy));
        check({tag, "_fault"}, 32'(fault), 32'(flt));
        check({tag, "_retry"}, 32'(retry_cnt), 32'(rc));
    endtask

    initial begin
        sys_rst_n = 1'b0;
        locked    = 1'b1;
        cfg_done  = 1'b0;
        soft_rst  = 1'b0;
        ticks(3);
        check_outputs("reset", ST_WAIT_LOCK, 4'h0, 1'b0, 1'b0, 2'd0);

        // Nominal: edge numbers counted from the deassertion of sys_rst_n.
        sys_rst_n = 1'b1;
        ticks(6);
        check("nom_wait_lock_c6", 32'(state), 32'(ST_WAIT_LOCK));
        tick();
        check("nom_por_entry_c7", 32'(state), 32'(ST_POR_WAIT));
        ticks(99);
        check_outputs("nom_por_last", ST_POR_WAIT, 4'h0, 1'b0, 1'b0, 2'd0);
        tick();
        check_outputs("nom_rel0", ST_RELEASE, 4'h1, 1'b0, 1'b0, 2'd0);
        ticks(9);
        check("nom_dom_c116", 32'(domain_rst_n), 32'h1);
        tick();
        check("nom_dom_c117", 32'(domain_rst_n), 32'h3);
        ticks(10);
        check("nom_dom_c127", 32'(domain_rst_n), 32'h7);
        ticks(10);
        check("nom_dom_c137", 32'(domain_rst_n), 32'hf);
        check("nom_rel_c137", 32'(state), 32'(ST_RELEASE));
        tick();
        check("nom_wcfg_c138", 32'(state), 32'(ST_WAIT_CFG));
        ticks(49);
        cfg_done = 1'b1;
        ticks(2);
        check("nom_ready_early", 32'(all_ready), 32'h0);
        tick();
        check_outputs("nom_run", ST_RUN, 4'hf, 1'b1, 1'b0, 2'd0);

        // cfg_done falling in RUN is ignored.
        cfg_done = 1'b0;
        ticks(5);
        check_outputs("run_hold", ST_RUN, 4'hf, 1'b1, 1'b0, 2'd0);

        // Lock glitch during RELEASE.
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        check_outputs("soft_from_run", ST_WAIT_LOCK, 4'h0, 1'b0, 1'b0, 2'd0);
        wait_dom("glitch_reach_0011", 4'h3, 300);
        locked = 1'b0;
        tick();
        locked = 1'b1;
        cnt = 1;
        while (domain_rst_n !== 4'h0 && cnt < 4) begin
            tick();
            cnt++;
        end
        check("glitch_dom_cleared", 32'(domain_rst_n), 32'h0);
        check("glitch_wait_lock", 32'(state), 32'(ST_WAIT_LOCK));
        wait_state("glitch_por_again", ST_POR_WAIT, 20);
        measure(ST_POR_WAIT, cnt);
        check("glitch_por_len", 32'(cnt), 32'd100);
        check("glitch_rel_dom", 32'(domain_rst_n), 32'h1);

        // Retry: cfg_done stays low through three timeouts.
        wait_state("retry1_wcfg", ST_WAIT_CFG, 100);
        check("retry1_dom_full", 32'(domain_rst_n), 32'hf);
        measure(ST_WAIT_CFG, cnt);
        check("retry1_wcfg_len", 32'(cnt), 32'd200);
        check_outputs("retry1", ST_POR_WAIT, 4'h0, 1'b0, 1'b0, 2'd1);
        wait_state("retry2_wcfg", ST_WAIT_CFG, 300);
        check("retry2_dom_full", 32'(domain_rst_n), 32'hf);
        measure(ST_WAIT_CFG, cnt);
        check_outputs("retry2", ST_POR_WAIT, 4'h0, 1'b0, 1'b0, 2'd2);
        wait_state("retry3_wcfg", ST_WAIT_CFG, 300);
        measure(ST_WAIT_CFG, cnt);
        check_outputs("fault", ST_FAULT, 4'h0, 1'b0, 1'b1, 2'd2);

        // FAULT is not left on lock loss.
        locked = 1'b0;
        tick();
        locked = 1'b1;
        ticks(8);
        check_outputs("fault_lockloss", ST_FAULT, 4'h0, 1'b0, 1'b1, 2'd2);

        // Soft reset from FAULT, then a nominal completion.
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        check_outputs("soft_from_fault", ST_WAIT_LOCK, 4'h0, 1'b0, 1'b0, 2'd0);
        wait_state("soft_nom_wcfg", ST_WAIT_CFG, 300);
        cfg_done = 1'b1;
        wait_state("soft_nom_run", ST_RUN, 10);
        check_outputs("soft_nom", ST_RUN, 4'hf, 1'b1, 1'b0, 2'd0);

        // cfg_done reaches the FSM on exactly the timeout cycle (retry_cnt=1 beforehand).
        cfg_done = 1'b0;
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        wait_state("simul_wcfg_a", ST_WAIT_CFG, 300);
        measure(ST_WAIT_CFG, cnt);
        check("simul_retry_pre", 32'(retry_cnt), 32'd1);
        wait_state("simul_wcfg_b", ST_WAIT_CFG, 300);
        ticks(197);
        cfg_done = 1'b1;
        ticks(2);
        check("simul_still_wcfg", 32'(state), 32'(ST_WAIT_CFG));
        tick();
        check_outputs("simul_run", ST_RUN, 4'hf, 1'b1, 1'b0, 2'd1);

        // soft_rst on the same edge as lock loss: soft_rst wins and clears retry_cnt.
        locked = 1'b0;
        ticks(3);
        check("soft_lock_pre", 32'(state), 32'(ST_RUN));
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        locked   = 1'b1;
        check_outputs("soft_lock", ST_WAIT_LOCK, 4'h0, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset between edges during RELEASE.
        cfg_done = 1'b0;
        wait_dom("async_reach_0011", 4'h3, 300);
        check("async_pre_state", 32'(state), 32'(ST_RELEASE));
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_outputs("async_rst", ST_WAIT_LOCK, 4'h0, 1'b0, 1'b0, 2'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        check_outputs("async_after", ST_WAIT_LOCK, 4'h0, 1'b0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
